// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the ARM-style core.
// Optional perf counters (retired_count, cycle_count) are built when SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
    parameter int WAIT_LIMIT = 15
`ifdef SEQ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic [1:0] TypeCode,
    input  logic       Load,
    input  logic       set_cond_bit,
    input  logic       should_store_link,
    input  logic       cond_pass,
    output logic       imem_req,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic       link_write,
    output logic       cpsr_write,
    output logic       pc_write,
    output logic       pc_branch_sel,
    output logic       fault,
    output logic [2:0] state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd7
    } state_e;

    localparam logic [7:0] WAIT_M1 = 8'(WAIT_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       fault_q;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        link_write    = 1'b0;
        cpsr_write    = 1'b0;
        pc_write      = 1'b0;
        pc_branch_sel = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    wait_d   = 8'd0;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_M1) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!cond_pass) begin
                    pc_write = 1'b1;
                    wait_d   = 8'd0;
                    state_d  = S_FETCH;
                end else if (TypeCode == 2'b10) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (TypeCode)
                    2'b00: begin
                        reg_write  = 1'b1;
                        cpsr_write = set_cond_bit;
                        pc_write   = 1'b1;
                        wait_d     = 8'd0;
                        state_d    = S_FETCH;
                    end
                    2'b01: begin
                        wait_d  = 8'd0;
                        state_d = S_MEMORY;
                    end
                    2'b11: begin
                        pc_write      = 1'b1;
                        pc_branch_sel = 1'b1;
                        link_write    = should_store_link;
                        wait_d        = 8'd0;
                        state_d       = S_FETCH;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = ~Load;
                if (dmem_ack) begin
                    wait_d = 8'd0;
                    if (Load) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (wait_q == WAIT_M1) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wait_d    = 8'd0;
                state_d   = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        // Held in reset: no request and no write strobe may leak out.
        if (!rst) begin
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            reg_write     = 1'b0;
            link_write    = 1'b0;
            cpsr_write    = 1'b0;
            pc_write      = 1'b0;
            pc_branch_sel = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_q | (state_d == S_FAULT);
        end
    end

    assign fault = fault_q;
    assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] ret_q, cyc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_q <= '0;
            cyc_q <= '0;
        end else if (state_q != S_FAULT) begin
            if (pc_write) ret_q <= ret_q + CNT_W'(1);
            if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    assign retired_count = ret_q;
    assign cycle_count   = cyc_q;
`endif

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the ARM-style core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the write enables of the instruction register, register bank, CPSR and PC, and the request/ack handshakes to instruction and data memory. It consumes the field outputs of the instruction decoder, latched from the IR, plus the CPSR condition result.

## Interface
- WAIT_LIMIT, 15: max consecutive cycles a memory request may wait for ack before fault (1..255).
- CNT_W, 32: width of performance counters (only with SEQ_PERF_CNT_EN).

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_ack  in  1  instruction memory ack; IR data valid this cycle
- dmem_ack  in  1  data memory ack; load data valid / store accepted this cycle
- TypeCode  in  2  decoder type: 00 data-proc, 01 memory, 11 branch, 10 illegal
- Load  in  1  memory op direction: 1 load, 0 store
- set_cond_bit  in  1  data-proc updates CPSR flags
- should_store_link  in  1  branch writes return address to link register
- cond_pass  in  1  CPSR evaluation of CondField; 1 = execute
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- reg_write  out  1  register bank write of Rd
- link_write  out  1  register bank write of link register
- cpsr_write  out  1  CPSR flag update
- pc_write  out  1  PC update (marks retirement)
- pc_branch_sel  out  1  PC source: 1 branch target, 0 PC+4
- fault  out  1  sticky fault (illegal TypeCode or memory timeout)
- state  out  3  current FSM state
- retired_count  out  CNT_W  instructions retired (SEQ_PERF_CNT_EN only)
- cycle_count  out  CNT_W  cycles since reset, saturating (SEQ_PERF_CNT_EN only)

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, FAULT=7. Codes 5 and 6 are unused and recover to FAULT.
- State, wait counter, fault and perf counters are registered. All strobes are combinational from the current state and inputs.
- FETCH: imem_req=1. On imem_ack: ir_write=1 and go to DECODE.
- DECODE: one cycle; decoder fields are valid from here on (IR held).
  - cond_pass=0: pc_write=1, pc_branch_sel=0, go to FETCH (skipped instruction, still retired).
  - TypeCode=10: go to FAULT.
  - Otherwise: go to EXECUTE.
- EXECUTE:
  - 00: reg_write=1, cpsr_write=set_cond_bit, pc_write=1, go to FETCH.
  - 01: go to MEMORY.
  - 11: pc_write=1, pc_branch_sel=1, link_write=should_store_link, go to FETCH.
- MEMORY: dmem_req=1, dmem_we=~Load.
  - On dmem_ack with Load=1: go to WRITEBACK.
  - On dmem_ack with Load=0: pc_write=1, go to FETCH.
- WRITEBACK: reg_write=1, pc_write=1, go to FETCH.
- FAULT: all strobes 0, fault=1. Exits only on reset.
- Wait counter:
  - Clears on entry to FETCH or MEMORY and on any ack.
  - Increments each cycle imem_req or dmem_req is high without ack.
  - Reaching WAIT_LIMIT with no ack in that cycle goes to FAULT next cycle.
  - An ack in the same cycle the limit is reached wins; no fault.

## Timing
- Reset (rst=0): state=FETCH, all strobes 0 except imem_req=1 combinationally once rst deasserts. fault=0, counters 0.
- Reset mid-operation aborts immediately. Requests drop asynchronously and no partial write strobes are issued.
- Zero-wait latency, measured from the FETCH cycle with ack to pc_write:
  - skip: 2 cycles
  - data-proc: 3 cycles
  - branch: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each ack wait cycle adds 1 cycle.
- Requests stay high until ack; ack while the matching req is low is ignored.
- At most one of reg_write/link_write is asserted per cycle. pc_write pulses exactly once per instruction.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - retired_count increments on each pc_write, wrapping at 2^CNT_W.
  - cycle_count increments every cycle and saturates at all-ones.
  - Both clear on reset; both freeze in FAULT.
- SEQ_PERF_CNT_EN undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset, then data-proc (TypeCode=00, set_cond_bit=1, cond_pass=1), acks immediate -> ir_write at cycle 1, reg_write+cpsr_write+pc_write at cycle 3, state returns to 0.
- Load (TypeCode=01, Load=1) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, reg_write+pc_write in WRITEBACK, total 8 cycles, retired_count=1.
- Branch with link (TypeCode=11, should_store_link=1) -> pc_branch_sel=1, link_write=1, pc_write=1 in EXECUTE; reg_write=0.
- cond_pass=0 on a store -> no dmem_req, pc_write with pc_branch_sel=0 in DECODE.
- TypeCode=10 -> FAULT (state=7, fault=1) and it holds; withholding imem_ack for WAIT_LIMIT=15 cycles -> fault; ack on the 15th cycle -> no fault.
- rst pulsed low during MEMORY with dmem_req=1 -> dmem_req drops in the same cycle, state=0, counters cleared.
